// File: rtl/data_mem_responder_pkg.sv
// Shared RV32I load/store encodings, FSM state type and lane helpers for the data memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Select the addressed lane(s) of a stored word and sign/zero-extend to 32 bits
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'h0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'h0, h};
      F3_W:    load_extend = word;
      default: load_extend = 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] addr_lo,
                                          input logic [2:0] funct3);
    case (funct3)
      F3_B:    store_be = 4'b0001 << addr_lo;
      F3_H:    store_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the memory stage (master) and the responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// Word-organised single-port RAM with byte-enable writes and a registered read port.
module dmem_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // Read returns the pre-write contents; stores never report read data
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Load/store target: accepts one request, waits LATENCY cycles, accesses the array, holds the response.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);
  localparam int unsigned CW = 4;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          load_ok;
  logic [31:0]   rd_word;

  logic          access_c;
  logic          acc_we_c;
  logic [2:0]    acc_f3_c;
  logic [31:0]   acc_addr_c;
  logic [31:0]   acc_wd_c;
  logic [31:0]   acc_wlanes_c;
  logic          acc_err_c;

  function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr[0];
      F3_W:    bad = |addr[1:0];
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    return bad | (|(addr >> (ADDR_WIDTH + 2)));
  endfunction

  // With zero latency the access uses the live bus fields on the acceptance edge
  always_comb begin
    access_c   = 1'b0;
    acc_we_c   = we_q;
    acc_f3_c   = f3_q;
    acc_addr_c = addr_q;
    acc_wd_c   = wdata_q;
    if (state == IDLE) begin
      acc_we_c   = bus.req_we;
      acc_f3_c   = bus.req_funct3;
      acc_addr_c = bus.req_addr;
      acc_wd_c   = bus.req_wdata;
      access_c   = bus.req_valid && (LATENCY == 0);
    end else if (state == WAIT) begin
      access_c   = (cnt == CW'(1));
    end
    acc_err_c = req_error(acc_we_c, acc_f3_c, acc_addr_c);
    case (acc_f3_c)
      F3_B:    acc_wlanes_c = {4{acc_wd_c[7:0]}};
      F3_H:    acc_wlanes_c = {2{acc_wd_c[15:0]}};
      default: acc_wlanes_c = acc_wd_c;
    endcase
  end

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (access_c),
    .we    (access_c && acc_we_c && !acc_err_c),
    .addr  (acc_addr_c[ADDR_WIDTH+1:2]),
    .be    (store_be(acc_addr_c[1:0], acc_f3_c)),
    .wdata (acc_wlanes_c),
    .rdata (rd_word)
  );

  assign bus.rsp_rdata = load_ok ? load_extend(rd_word, addr_q[1:0], f3_q) : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      load_ok       <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            f3_q          <= bus.req_funct3;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            cnt           <= CW'(LATENCY);
            bus.req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= acc_err_c;
              load_ok       <= !acc_err_c && !acc_we_c;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            state         <= RESP;
            cnt           <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= acc_err_c;
            load_ok       <= !acc_err_c && !acc_we_c;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
            load_ok       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: the same scenario suite against three responders built with LATENCY 2, 0 and 15.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b0;
  int          sel = 0;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();
  data_mem_responder_if if2 ();

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.rsp_ready = rsp_ready && (sel == 0);
  assign if1.rsp_ready = rsp_ready && (sel == 1);
  assign if2.rsp_ready = rsp_ready && (sel == 2);
  assign if0.req_we = req_we;     assign if1.req_we = req_we;     assign if2.req_we = req_we;
  assign if0.req_funct3 = req_f3; assign if1.req_funct3 = req_f3; assign if2.req_funct3 = req_f3;
  assign if0.req_addr = req_addr; assign if1.req_addr = req_addr; assign if2.req_addr = req_addr;
  assign if0.req_wdata = req_wdata; assign if1.req_wdata = req_wdata; assign if2.req_wdata = req_wdata;

  always_comb begin
    case (sel)
      1:       begin o_ready = if1.req_ready; o_valid = if1.rsp_valid; o_rdata = if1.rsp_rdata; o_err = if1.rsp_err; end
      2:       begin o_ready = if2.req_ready; o_valid = if2.rsp_valid; o_rdata = if2.rsp_rdata; o_err = if2.rsp_err; end
      default: begin o_ready = if0.req_ready; o_valid = if0.rsp_valid; o_rdata = if0.rsp_rdata; o_err = if0.rsp_err; end
    endcase
  end

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2))  dut0 (.clk(clk), .reset(reset), .bus(if0));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0))  dut1 (.clk(clk), .reset(reset), .bus(if1));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  function automatic int lat_exp();
    return (sel == 1) ? 0 : (sel == 2) ? 15 : 2;
  endfunction

  // One full transaction; optionally holds rsp_ready low for 'hold' cycles once the response is up
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int hold, input string name);
    int cyc;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL %s[%0d] req_ready: got %b want 1", name, sel, o_ready); end
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (o_valid !== 1'b1 && cyc < 40);
    total++;
    if (cyc != lat_exp() + 1) begin bad++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, sel, cyc, lat_exp() + 1); end
    total++;
    if (o_rdata !== exp_rd) begin bad++; $display("FAIL %s[%0d] rdata: got %h want %h", name, sel, o_rdata, exp_rd); end
    total++;
    if (o_err !== exp_err) begin bad++; $display("FAIL %s[%0d] err: got %b want %b", name, sel, o_err, exp_err); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_rdata !== exp_rd)
        begin bad++; $display("FAIL %s[%0d] hold%0d: got v=%b r=%b d=%h want v=1 r=0 d=%h", name, sel, i, o_valid, o_ready, o_rdata, exp_rd); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1)
      begin bad++; $display("FAIL %s[%0d] release: got v=%b r=%b want v=0 r=1", name, sel, o_valid, o_ready); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_rdata !== 32'h0 || o_err !== 1'b0)
      begin bad++; $display("FAIL reset[%0d]: got r=%b v=%b d=%h e=%b want r=1 v=0 d=0 e=0", sel, o_ready, o_valid, o_rdata, o_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word();
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw");
    do_req(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw");
  endtask

  task automatic test_subword_load();
    do_req(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 0, "lb");
    do_req(1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 0, "lbu");
    do_req(1'b0, F3_H,  32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 0, "lh");
    do_req(1'b0, F3_HU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 0, "lhu");
  endtask

  task automatic test_subword_store();
    do_req(1'b1, F3_B, 32'h11, 32'h000000AA, 32'h0, 1'b0, 0, "sb");
    do_req(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, 0, "lw_sb");
    do_req(1'b1, F3_H, 32'h12, 32'h00001234, 32'h0, 1'b0, 0, "sh");
    do_req(1'b0, F3_W, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 0, "lw_sh");
  endtask

  task automatic test_errors();
    do_req(1'b0, F3_W,   32'h12,   32'h0,      32'h0, 1'b1, 0, "err_lw_mis");
    do_req(1'b1, F3_H,   32'h11,   32'hFFFF,   32'h0, 1'b1, 0, "err_sh_mis");
    do_req(1'b0, 3'b011, 32'h10,   32'h0,      32'h0, 1'b1, 0, "err_f3_011");
    do_req(1'b1, F3_BU,  32'h10,   32'hFF,     32'h0, 1'b1, 0, "err_sbu");
    do_req(1'b0, F3_W,   32'h1000, 32'h0,      32'h0, 1'b1, 0, "err_range_lw");
    do_req(1'b1, F3_W,   32'h1010, 32'h0,      32'h0, 1'b1, 0, "err_range_sw");
    do_req(1'b0, F3_W,   32'h10,   32'h0, 32'h1234AAEF, 1'b0, 0, "lw_after_err");
  endtask

  task automatic test_backpressure();
    do_req(1'b0, F3_W, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 5, "bp");
  endtask

  // Reset during WAIT drops the store; with zero latency it lands in RESP after the store committed
  task automatic test_reset_mid();
    logic [31:0] exp_word;
    do_req(1'b1, F3_W, 32'h20, 32'h11111111, 32'h0, 1'b0, 0, "sw_pre");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = F3_W; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_valid !== (lat_exp() == 0))
      begin bad++; $display("FAIL midrst_pre[%0d] valid: got %b want %b", sel, o_valid, lat_exp() == 0); end
    reset = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_rdata !== 32'h0 || o_err !== 1'b0)
      begin bad++; $display("FAIL midrst[%0d]: got r=%b v=%b d=%h e=%b want r=1 v=0 d=0 e=0", sel, o_ready, o_valid, o_rdata, o_err); end
    @(negedge clk);
    reset = 1'b0;
    exp_word = (lat_exp() == 0) ? 32'h55 : 32'h11111111;
    do_req(1'b0, F3_W, 32'h20, 32'h0, exp_word, 1'b0, 0, "lw_midrst");
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      sel = s;
      test_reset();
      test_word();
      test_subword_load();
      test_subword_store();
      test_errors();
      test_backpressure();
      test_reset_mid();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
